// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash read arbiter: FSM state encoding,
// transfer owner encoding and the word returned on a timed-out read.
package flash_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Data word handed back to the requester when the flash never finished
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

  // Last count value of the WAIT_BUSY watchdog before the strobe is repeated
  localparam logic [1:0] RESTROBE_LAST = 2'd3;

endpackage

// File: rtl/flash_arb_grant.sv
// Grant decision for the flash read arbiter: picks one of the two pending
// read ports. On contention it either alternates against the last served
// port (ROUND_ROBIN=1) or always favours the data port (ROUND_ROBIN=0).
module flash_arb_grant
  import flash_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_served,
  output logic   grant,
  output owner_t grant_owner
);

  // Pick the winner; the owner output only matters when grant is high
  always_comb begin
    grant       = i_req | d_req;
    grant_owner = OWN_D;
    if (i_req && d_req) begin
      if (ROUND_ROBIN != 0) begin
        grant_owner = (last_served == OWN_D) ? OWN_I : OWN_D;
      end
    end else if (i_req) begin
      grant_owner = OWN_I;
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Flash read arbiter: shares one SPI flash word reader between the
// instruction-fetch port and the data-load port. One transfer at a time,
// strobe re-issued if the reader never goes busy, aborted with an error
// word if the reader stays busy for TIMEOUT cycles (valid range 1..255).
// Optional build macro FLASH_ARB_CACHE_EN adds a one-entry read cache that
// answers a repeated address without touching the flash.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [19:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic [19:0] d_addr,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        err,
  output logic        f_rstrb,
  output logic [19:0] f_addr,
  input  logic [31:0] f_rdata,
  input  logic        f_rbusy
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  owner_t      owner;
  owner_t      last_served;
  logic [7:0]  wait_cnt;
  logic [1:0]  busy_cnt;

  logic        grant;
  owner_t      grant_owner;
  logic [19:0] grant_addr;

  logic        cache_hit;
  logic [31:0] cache_data;

  logic        deliver;
  owner_t      deliver_owner;
  logic [31:0] deliver_data;
  logic        deliver_err;

  flash_arb_grant #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_grant (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_served (last_served),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  assign grant_addr = (grant_owner == OWN_I) ? i_addr : d_addr;

  // The strobe is gated by f_rbusy so a reader still finishing an aborted
  // transfer is never strobed; ISSUE simply waits for it to go idle.
  assign f_rstrb = (state == ISSUE) && !f_rbusy;

`ifdef FLASH_ARB_CACHE_EN
  logic        cache_valid;
  logic [19:0] cache_tag;

  assign cache_hit = cache_valid && (cache_tag == grant_addr);

  // One-entry cache, refreshed by every read the flash actually completed
  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if (state == WAIT_DONE && !f_rbusy) begin
      cache_valid <= 1'b1;
      cache_tag   <= f_addr;
      cache_data  <= f_rdata;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Decide whether a response is launched this cycle and what it carries
  always_comb begin
    deliver       = 1'b0;
    deliver_owner = owner;
    deliver_data  = f_rdata;
    deliver_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant && cache_hit) begin
          deliver       = 1'b1;
          deliver_owner = grant_owner;
          deliver_data  = cache_data;
        end
      end
      WAIT_DONE: begin
        if (!f_rbusy) begin
          deliver = 1'b1;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          deliver      = 1'b1;
          deliver_data = ERR_WORD;
          deliver_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transfer sequencing: grant, strobe, wait for busy, wait for done, respond
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      last_served <= OWN_D;
      f_addr      <= '0;
      wait_cnt    <= '0;
      busy_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner       <= grant_owner;
            last_served <= grant_owner;
            f_addr      <= grant_addr;
            state       <= cache_hit ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          if (!f_rbusy) begin
            busy_cnt <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (f_rbusy) begin
            wait_cnt <= '0;
            state    <= WAIT_DONE;
          end else if (busy_cnt == RESTROBE_LAST) begin
            state <= ISSUE;
          end else begin
            busy_cnt <= busy_cnt + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (!f_rbusy || wait_cnt == TIMEOUT_LAST) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Response registers: data held between responses, valid/err pulse in RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      if (deliver) begin
        if (deliver_owner == OWN_I) begin
          i_rdata <= deliver_data;
          i_valid <= 1'b1;
        end else begin
          d_rdata <= deliver_data;
          d_valid <= 1'b1;
        end
        err <= deliver_err;
      end
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: per-port request drivers, a
// behavioural SPI flash reader model, and a scoreboard fed by a transaction
// level model of the arbitration, timeout and optional cache rules.
module tb_flash_read_arbiter;

  localparam int TB_TIMEOUT     = 255;
  localparam int DRIVER_BUDGET  = 1500;
  localparam int PHASE_BUDGET   = 3000;
`ifdef FLASH_ARB_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [19:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req = 1'b0;
  logic [19:0] d_addr = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        err;
  logic        f_rstrb;
  logic [19:0] f_addr;
  logic [31:0] f_rdata = '0;
  logic        f_rbusy = 1'b0;

  flash_read_arbiter #(
    .ROUND_ROBIN (1),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_valid (i_valid),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_rdata (d_rdata),
    .d_valid (d_valid),
    .err     (err),
    .f_rstrb (f_rstrb),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_rbusy (f_rbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          err;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  resp_t       exp_q[$];
  logic [31:0] exp_i_last = '0;
  logic [31:0] exp_d_last = '0;

  // Transaction-level model state
  bit          m_last_is_d = 1'b1;
  bit          m_cache_valid = 1'b0;
  logic [19:0] m_cache_tag = '0;

  // Flash model configuration and observations
  int          cfg_lat = 10;
  bit          cfg_ign = 1'b0;
  int          strobe_count = 0;
  logic [19:0] last_strobe_addr = '0;
  int          last_strobe_cycle = 0;
  bit          ignored_last = 1'b0;

  // Driver work queues and per-phase item lists
  logic [19:0] i_todo_addr[$];
  bit          i_todo_drop[$];
  logic [19:0] d_todo_addr[$];
  bit          d_todo_drop[$];
  bit          i_busy = 1'b0;
  bit          d_busy = 1'b0;
  logic [19:0] ph_i_addr[$];
  bit          ph_i_drop[$];
  logic [19:0] ph_d_addr[$];
  bit          ph_d_drop[$];

  // Contents of the flash as seen through the reader
  function automatic logic [31:0] flashWord(input logic [19:0] a);
    if (a == 20'h00010) return 32'h12345678;
    return {a[7:0], a[19:8], a[11:0]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Flash reader model: samples the strobe mid-cycle, reacts after the edge
  initial begin : flash_model
    bit          s;
    bit          accept;
    logic [19:0] sa;
    logic [19:0] paddr;
    int          left;
    accept = 1'b0;
    paddr  = '0;
    left   = 0;
    forever begin
      @(negedge clk);
      s  = (f_rstrb === 1'b1);
      sa = f_addr;
      if (s) begin
        checkOutput("strobe_while_busy", 32'(f_rbusy), 32'd0);
        strobe_count++;
        last_strobe_addr = sa;
        if (ignored_last) checkOutput("restrobe_gap", cycle - last_strobe_cycle, 32'd5);
        accept = !(cfg_ign && !ignored_last);
        ignored_last = !accept;
        last_strobe_cycle = cycle;
      end
      @(posedge clk);
      #1;
      if (s && accept) begin
        f_rbusy = 1'b1;
        left    = cfg_lat;
        paddr   = sa;
        f_rdata = $urandom;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          f_rbusy = 1'b0;
          f_rdata = flashWord(paddr);
        end
      end
    end
  end

  // Request driver for one port: holds a request until its valid pulse
  task automatic runDriver(input bit is_d);
    logic [19:0] a = '0;
    bit          drop = 1'b0;
    bit          active = 1'b0;
    bit          vld;
    int          age = 0;
    forever begin
      @(negedge clk);
      if (active) begin
        age++;
        vld = is_d ? (d_valid === 1'b1) : (i_valid === 1'b1);
        if (vld) begin
          active = 1'b0;
        end else if (age > DRIVER_BUDGET) begin
          checks++;
          errors++;
          $display("[TB] FAIL driver_wait port=%s addr=%h: no valid after %0d cycles, required within %0d",
                   is_d ? "d" : "i", a, age, DRIVER_BUDGET);
          active = 1'b0;
        end else if (drop && f_rbusy === 1'b1 && f_addr === a) begin
          if (is_d) d_req = 1'b0;
          else i_req = 1'b0;
        end
      end
      if (!active) begin
        if (is_d && d_todo_addr.size() > 0) begin
          a = d_todo_addr.pop_front();
          drop = d_todo_drop.pop_front();
          active = 1'b1;
          age = 0;
          d_addr = a;
          d_req = 1'b1;
        end else if (!is_d && i_todo_addr.size() > 0) begin
          a = i_todo_addr.pop_front();
          drop = i_todo_drop.pop_front();
          active = 1'b1;
          age = 0;
          i_addr = a;
          i_req = 1'b1;
        end else if (is_d) begin
          d_req = 1'b0;
        end else begin
          i_req = 1'b0;
        end
      end
      if (is_d) d_busy = active;
      else i_busy = active;
    end
  endtask

  initial runDriver(1'b0);
  initial runDriver(1'b1);

  // Scoreboard monitor: every valid pulse is matched against the model
  initial begin : monitor
    resp_t e;
    bit    got_d;
    forever begin
      @(negedge clk);
      if (i_valid === 1'b1 || d_valid === 1'b1) begin
        if (i_valid === 1'b1 && d_valid === 1'b1) begin
          checkOutput("both_valid", 32'd1, 32'd0);
        end else if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(d_valid), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          got_d = (d_valid === 1'b1);
          checkOutput("resp_port_is_d", 32'(got_d), 32'(e.is_d));
          checkOutput("resp_data", got_d ? d_rdata : i_rdata, e.data);
          checkOutput("resp_err", 32'(err), 32'(e.err));
          checkOutput("other_rdata_held", got_d ? i_rdata : d_rdata,
                      e.is_d ? exp_i_last : exp_d_last);
          if (e.is_d) exp_d_last = e.data;
          else exp_i_last = e.data;
        end
      end else if (err === 1'b1) begin
        checkOutput("err_without_valid", 32'(err), 32'd0);
      end
    end
  end

  task automatic waitPhase(input int exp_strobes, input int strobe_start);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q.size() != 0 || i_busy || d_busy ||
                i_todo_addr.size() != 0 || d_todo_addr.size() != 0) && t < PHASE_BUDGET);
    if (t >= PHASE_BUDGET) begin
      checks++;
      errors++;
      $display("[TB] FAIL phase_timeout: %0d responses outstanding after %0d cycles, required 0",
               exp_q.size(), t);
      exp_q.delete();
    end
    t = 0;
    while (f_rbusy === 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checkOutput("strobe_count", strobe_count - strobe_start, exp_strobes);
  endtask

  task automatic addItem(input bit is_d, input logic [19:0] a, input bit drop);
    if (is_d) begin
      ph_d_addr.push_back(a);
      ph_d_drop.push_back(drop);
    end else begin
      ph_i_addr.push_back(a);
      ph_i_drop.push_back(drop);
    end
  endtask

  // Predict the served order and responses for the queued items, then run them
  task automatic applyStimulus(input int lat, input bit ign);
    int          ii = 0;
    int          di = 0;
    int          exp_strobes = 0;
    int          strobe_start;
    bit          serve_d;
    logic [19:0] a;
    while (ii < ph_i_addr.size() || di < ph_d_addr.size()) begin
      if (ii < ph_i_addr.size() && di < ph_d_addr.size()) serve_d = !m_last_is_d;
      else serve_d = (di < ph_d_addr.size());
      a = serve_d ? ph_d_addr[di] : ph_i_addr[ii];
      if (serve_d) di++;
      else ii++;
      m_last_is_d = serve_d;
      if (CACHE_EN && m_cache_valid && m_cache_tag == a) begin
        exp_q.push_back('{serve_d, flashWord(a), 1'b0});
      end else begin
        exp_strobes += ign ? 2 : 1;
        if (lat - 1 >= TB_TIMEOUT) begin
          exp_q.push_back('{serve_d, 32'hFFFF_FFFF, 1'b1});
        end else begin
          exp_q.push_back('{serve_d, flashWord(a), 1'b0});
          m_cache_valid = 1'b1;
          m_cache_tag   = a;
        end
      end
    end
    cfg_lat = lat;
    cfg_ign = ign;
    strobe_start = strobe_count;
    @(posedge clk);
    #2;
    foreach (ph_i_addr[k]) begin
      i_todo_addr.push_back(ph_i_addr[k]);
      i_todo_drop.push_back(ph_i_drop[k]);
    end
    foreach (ph_d_addr[k]) begin
      d_todo_addr.push_back(ph_d_addr[k]);
      d_todo_drop.push_back(ph_d_drop[k]);
    end
    ph_i_addr.delete();
    ph_i_drop.delete();
    ph_d_addr.delete();
    ph_d_drop.delete();
    waitPhase(exp_strobes, strobe_start);
  endtask

  function automatic bit inPhase(input logic [19:0] a);
    foreach (ph_i_addr[k]) if (ph_i_addr[k] == a) return 1'b1;
    foreach (ph_d_addr[k]) if (ph_d_addr[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [19:0] pickAddr();
    logic [19:0] pool[4];
    logic [19:0] a;
    pool[0] = 20'h00400;
    pool[1] = 20'h00401;
    pool[2] = 20'h0ABCD;
    pool[3] = 20'hFFFFF;
    do begin
      if ($urandom_range(0, 1) == 0) a = pool[$urandom_range(0, 3)];
      else a = 20'($urandom);
    end while (inPhase(a));
    return a;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_i_valid"}, 32'(i_valid), 32'd0);
    checkOutput({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, "_f_addr"}, 32'(f_addr), 32'd0);
    checkOutput({tag, "_f_rstrb"}, 32'(f_rstrb), 32'd0);
  endtask

  // Reset in the middle of a transfer: it is dropped, then re-served
  task automatic resetDuringTransfer();
    int t = 0;
    int strobe_start = strobe_count;
    cfg_lat = 40;
    cfg_ign = 1'b0;
    exp_q.push_back('{1'b1, flashWord(20'h77777), 1'b0});
    @(posedge clk);
    #2;
    d_todo_addr.push_back(20'h77777);
    d_todo_drop.push_back(1'b0);
    while (f_rbusy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("reset_test_flash_busy", 32'(f_rbusy), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("midreset");
    reset = 1'b1;
    exp_i_last    = '0;
    exp_d_last    = '0;
    m_cache_valid = 1'b0;
    m_last_is_d   = 1'b1;
    waitPhase(2, strobe_start);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running after 90000 cycles, required to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    int ni;
    int nd;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b1;

    $display("[TB] contention straight after reset");
    addItem(1'b0, 20'h00100, 1'b0);
    addItem(1'b1, 20'h00200, 1'b0);
    applyStimulus(12, 1'b0);

    $display("[TB] both ports held for three reads each");
    for (int k = 0; k < 3; k++) begin
      addItem(1'b0, 20'h00101 + 20'(k), 1'b0);
      addItem(1'b1, 20'h00201 + 20'(k), 1'b0);
    end
    applyStimulus(8, 1'b0);

    $display("[TB] single instruction read, 70 busy cycles");
    addItem(1'b0, 20'h00010, 1'b0);
    applyStimulus(70, 1'b0);
    checkOutput("strobe_addr", 32'(last_strobe_addr), 32'h00010);

    $display("[TB] first strobe ignored by flash");
    addItem(1'b0, 20'h00333, 1'b0);
    applyStimulus(10, 1'b0 | 1'b1);

    $display("[TB] flash stuck busy on a data read");
    addItem(1'b1, 20'h00444, 1'b0);
    applyStimulus(300, 1'b0);

    $display("[TB] busy length at the timeout boundary");
    addItem(1'b0, 20'h00555, 1'b0);
    applyStimulus(255, 1'b0);
    addItem(1'b1, 20'h00556, 1'b0);
    applyStimulus(256, 1'b0);

    $display("[TB] reset during WAIT_DONE");
    resetDuringTransfer();

    $display("[TB] repeated read of one address");
    addItem(1'b0, 20'h00400, 1'b0);
    applyStimulus(20, 1'b0);
    addItem(1'b0, 20'h00400, 1'b0);
    applyStimulus(20, 1'b0);

    $display("[TB] randomized phases");
    for (int p = 0; p < 25; p++) begin
      ni = $urandom_range(0, 3);
      nd = $urandom_range(0, 3);
      if (ni == 0 && nd == 0) ni = 1;
      for (int k = 0; k < ni; k++) addItem(1'b0, pickAddr(), $urandom_range(0, 3) == 0);
      for (int k = 0; k < nd; k++) addItem(1'b1, pickAddr(), $urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(1, 40), $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
